// File: rtl/lsu_dbus_master.sv
// Memory-stage load/store unit: issues one single-beat data-bus transaction per EX/MEM request,
// extracts and extends load data, raises alignment and bus-error exceptions.
//
// state | meaning
// IDLE  | no transaction in flight; misaligned ops flagged here
// REQ   | dbus_req asserted from latched fields, waiting for dbus_gnt
// RESP  | granted, waiting for dbus_rvalid
// HOLD  | response captured while the pipeline was frozen; result presented until cpu_en
module lsu_dbus_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_en,
  input  logic        mem_flush,
  input  logic        ex_en,
  input  logic        ex_memory_rd_en,
  input  logic        ex_memory_we_en,
  input  logic [31:0] ex_alu_out,
  input  logic [2:0]  ex_mem_op,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_store_byteena,
  output logic        dbus_req,
  output logic [31:0] dbus_addr,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err,
  output logic        lsu_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        mem_exp,
  output logic [1:0]  mem_exp_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [1:0] EXP_LD_MIS = 2'd0;
  localparam logic [1:0] EXP_ST_MIS = 2'd1;
  localparam logic [1:0] EXP_LD_ERR = 2'd2;
  localparam logic [1:0] EXP_ST_ERR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        kill_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;

  logic        hold_valid_q;
  logic        hold_exp_q;
  logic [1:0]  hold_code_q;
  logic [31:0] hold_data_q;

  logic        op_valid;
  logic        is_store;
  logic        misaligned;
  logic        issue;
  logic        mis_exp;
  logic        killed;
  logic        resp_done;
  logic        rsp_valid;
  logic        rsp_exp;
  logic [1:0]  rsp_code;
  logic [31:0] ext_data;
  logic        in_idle, in_req, in_resp, in_hold;

  assign in_idle = (state_q == S_IDLE);
  assign in_req  = (state_q == S_REQ);
  assign in_resp = (state_q == S_RESP);
  assign in_hold = (state_q == S_HOLD);

  assign op_valid = ex_en & (ex_memory_rd_en | ex_memory_we_en) & ~mem_flush;
  assign is_store = ex_memory_we_en;

  always_comb begin
    misaligned = 1'b0;
    case (ex_mem_op[1:0])
      2'b01:   misaligned = ex_alu_out[0];
      2'b10:   misaligned = |ex_alu_out[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign issue   = in_idle & op_valid & ~misaligned & cpu_en;
  assign mis_exp = in_idle & op_valid & misaligned;

  // A flush arriving in the same cycle as rvalid still suppresses the result.
  assign killed    = kill_q | mem_flush;
  assign resp_done = in_resp & dbus_rvalid;
  assign rsp_valid = resp_done & ~killed & ~we_q & ~dbus_err;
  assign rsp_exp   = resp_done & ~killed & dbus_err;
  assign rsp_code  = we_q ? EXP_ST_ERR : EXP_LD_ERR;

  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    ext_data = 32'h0;
    case (off_q)
      2'd0:    byte_sel = dbus_rdata[7:0];
      2'd1:    byte_sel = dbus_rdata[15:8];
      2'd2:    byte_sel = dbus_rdata[23:16];
      default: byte_sel = dbus_rdata[31:24];
    endcase
    half_sel = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (op_q[1:0])
      2'b00:   ext_data = {{24{byte_sel[7] & ~op_q[2]}}, byte_sel};
      2'b01:   ext_data = {{16{half_sel[15] & ~op_q[2]}}, half_sel};
      default: ext_data = dbus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue) state_d = S_REQ;
      S_REQ:  if (dbus_gnt) state_d = S_RESP;
      S_RESP: if (dbus_rvalid) state_d = cpu_en ? S_IDLE : S_HOLD;
      S_HOLD: if (cpu_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_IDLE)
        kill_q <= 1'b0;
      else if ((in_req | in_resp) & mem_flush)
        kill_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      op_q    <= 3'd0;
      off_q   <= 2'd0;
    end else if (issue) begin
      addr_q  <= {ex_alu_out[31:2], 2'b00};
      we_q    <= is_store;
      be_q    <= is_store ? ex_store_byteena : 4'hF;
      wdata_q <= is_store ? ex_store_data : 32'h0;
      op_q    <= ex_mem_op;
      off_q   <= ex_alu_out[1:0];
    end
  end

  // Result capture for a response that lands while the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_exp_q   <= 1'b0;
      hold_code_q  <= 2'd0;
      hold_data_q  <= 32'h0;
    end else if (resp_done & ~cpu_en) begin
      hold_valid_q <= rsp_valid;
      hold_exp_q   <= rsp_exp;
      hold_code_q  <= rsp_code;
      hold_data_q  <= ext_data;
    end
  end

  assign dbus_req   = in_req;
  assign dbus_addr  = addr_q;
  assign dbus_we    = we_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;

  assign lsu_stall = (in_idle & op_valid & ~misaligned) | in_req | (in_resp & ~dbus_rvalid);

  always_comb begin
    mem_load_valid = 1'b0;
    mem_load_data  = 32'h0;
    mem_exp        = 1'b0;
    mem_exp_code   = 2'd0;
    if (rsp_valid) begin
      mem_load_valid = 1'b1;
      mem_load_data  = ext_data;
    end else if (in_hold & hold_valid_q) begin
      mem_load_valid = 1'b1;
      mem_load_data  = hold_data_q;
    end
    if (mis_exp) begin
      mem_exp      = 1'b1;
      mem_exp_code = is_store ? EXP_ST_MIS : EXP_LD_MIS;
    end else if (rsp_exp) begin
      mem_exp      = 1'b1;
      mem_exp_code = rsp_code;
    end else if (in_hold & hold_exp_q) begin
      mem_exp      = 1'b1;
      mem_exp_code = hold_code_q;
    end
  end

endmodule

// File: doc/lsu_dbus_master.md
# lsu_dbus_master

Memory-stage load/store unit servicing the requests held in the EX/MEM pipeline register. It is the responder for the EX/MEM memory-request fields. It checks alignment and issues one single-beat transaction on the data bus. It then returns lane-extracted, sign- or zero-extended load data to the MEM/WB stage and stalls the pipeline until the transaction completes. Exceptions (misaligned access, bus error) go to cpu_ctrl.

## Interface
- No parameters; widths are fixed. Word = 32 bits; mem_op = 3 bits, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cpu_en  in  1  global pipeline advance enable
- mem_flush  in  1  kill the op currently in EX/MEM
- ex_en  in  1  EX/MEM slot valid
- ex_memory_rd_en  in  1  load request
- ex_memory_we_en  in  1  store request
- ex_alu_out  in  32  byte address
- ex_mem_op  in  3  access size/sign
- ex_store_data  in  32  store data, already lane-aligned
- ex_store_byteena  in  4  store byte enables, already lane-aligned
- dbus_req  out  1  request
- dbus_addr  out  32  word address, {addr[31:2],2'b00}
- dbus_we  out  1  1 = write
- dbus_be  out  4  byte enables (loads: 4'b1111)
- dbus_wdata  out  32  write data
- dbus_gnt  in  1  request accepted this cycle
- dbus_rvalid  in  1  response valid; exactly one per granted request, reads and writes
- dbus_rdata  in  32  read data
- dbus_err  in  1  bus error, qualified by dbus_rvalid
- lsu_stall  out  1  hold pipeline
- mem_load_data  out  32  extended load result
- mem_load_valid  out  1  load result valid
- mem_exp  out  1  exception pulse
- mem_exp_code  out  2  0 load misaligned, 1 store misaligned, 2 load bus error, 3 store bus error

## Operation
- op_valid = ex_en & (rd_en | we_en) & ~mem_flush. A store takes priority if both rd_en and we_en are set.
- Misaligned access: H/HU/SH with addr[0]=1, or W with addr[1:0]≠0.
- States: IDLE, REQ, RESP, HOLD.
- IDLE:
  - op_valid & cpu_en & aligned: latch addr, we, be, wdata, mem_op and addr[1:0]; go to REQ.
  - op_valid & misaligned: mem_exp=1 with code 0 or 1 (combinational); no bus activity; stay in IDLE.
- REQ: dbus_req=1, driven from the latched values. Request fields stay stable until dbus_gnt=1, then go to RESP.
- RESP: wait for dbus_rvalid.
  - On rvalid with cpu_en=1: go to IDLE.
  - On rvalid with cpu_en=0: capture the result and go to HOLD.
- HOLD: lsu_stall=0 and the captured result is presented. Go to IDLE on the first cycle with cpu_en=1; the op is not reissued.
- Load extraction: select the byte or half at the latched offset, then sign-extend (B/H) or zero-extend (BU/HU). W passes through.
- On rvalid in RESP (or in HOLD, from the capture register):
  - A load with err=0 drives mem_load_valid=1 and mem_load_data.
  - err=1 drives mem_exp=1 with code 2 or 3, and mem_load_valid=0.
  - Stores produce no data.
- lsu_stall = (IDLE & op_valid & aligned) | REQ | (RESP & ~dbus_rvalid).
- Flush:
  - In IDLE, mem_flush suppresses issue.
  - In REQ or RESP, set a kill flag. The bus transaction still completes per protocol, and lsu_stall stays high until rvalid.
  - The completion of a killed op produces no load_valid and no exp.
  - The kill flag clears on return to IDLE.

## Timing
- Reset: state IDLE, kill flag 0. Outputs: dbus_req=0, dbus_addr=0, dbus_we=0, dbus_be=0, dbus_wdata=0, lsu_stall=0, mem_load_data=0, mem_load_valid=0, mem_exp=0, mem_exp_code=0.
- Latency with zero-wait gnt and next-cycle rvalid:
  - C0: op visible, stall=1.
  - C1: req=gnt=1.
  - C2: rvalid=1, load_valid=1, stall=0.
  - The MEM/WB register captures at the end of C2.
- mem_load_valid and mem_exp are single-cycle, except in HOLD, where they persist until cpu_en=1.
- dbus_req is never deasserted before dbus_gnt.
- Only one transaction is outstanding; no new req is issued before rvalid.
- Asserting rst_n mid-transaction forces IDLE immediately. Any bus response that follows is ignored.

## Test plan
- LW at 0x1000, gnt same cycle, rdata=0xDEADBEEF next cycle -> dbus_addr=0x1000, be=1111, load_valid=1 and data=0xDEADBEEF in C2, stall high for C0–C1 only.
- LB at 0x1003, rdata=0x80123456 -> 0xFFFFFF80. LHU at 0x1002, rdata=0xBEEF1234 -> 0x0000BEEF. LH at 0x1000, rdata=0x0000F00D -> 0xFFFFF00D.
- SW at 0x1001 -> no dbus_req, mem_exp=1 with code 1, stall=0. LH at 0x2001 -> code 0.
- SB at 0x3002, be=0100, gnt delayed 3 cycles -> req, addr=0x3000 and be stable for all 4 cycles; stall released on rvalid.
- LW with rvalid+err=1 -> mem_exp=1 with code 2, load_valid=0. Same with mem_flush raised during RESP -> no exp, no valid, stall held until rvalid.
- cpu_en=0 at rvalid of LW returning 0x12345678 -> HOLD, data held, stall=0. When cpu_en rises: IDLE, no second dbus_req.
